// File: rtl/gc_word_packer_pkg.sv
// Shared constants and helpers for the Gollmann-cascade word packer.
package gc_pkg;

  localparam int GC_WIDTH     = 8;
  localparam int GC_DEPTH     = 4;
  localparam int GC_RPT_LIMIT = 16;
  localparam int GC_DROP_W    = 8;

  // Ceiling log2; used for elaboration-time widths only.
  function automatic int gc_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/gc_word_packer_if.sv
// Valid/ready word stream from the packer to its consumer.
interface gc_word_packer_if
  import gc_pkg::*;
#(
  parameter int WIDTH = GC_WIDTH
);

  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;

  modport master (output word_out, output word_valid, input word_ready);
  modport slave  (input word_out, input word_valid, output word_ready);

endinterface

// File: rtl/gc_word_packer_sync_fifo.sv
// Small synchronous FIFO; the head entry is read straight out of the storage registers.
module gc_sync_fifo
  import gc_pkg::*;
#(
  parameter int WIDTH = GC_WIDTH,
  parameter int DEPTH = GC_DEPTH,
  localparam int AW   = gc_clog2(DEPTH),
  localparam int CW   = gc_clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // When full, a push is only taken if the head leaves on the same edge.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/gc_word_packer.sv
// Packs sampled keystream bits MSB-first into words, buffers them, and runs a
// repetition-count health test with sticky overflow/stuck flags for software.
module gc_word_packer
  import gc_pkg::*;
#(
  parameter int WIDTH     = GC_WIDTH,
  parameter int DEPTH     = GC_DEPTH,
  parameter int RPT_LIMIT = GC_RPT_LIMIT,
  parameter int DROP_W    = GC_DROP_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              bit_in_i,
  input  logic              bit_en_i,
  input  logic              clr_i,
  gc_word_packer_if.master  word_if,
  output logic              overflow_o,
  output logic              stuck_err_o,
  output logic [DROP_W-1:0] drop_cnt_o
);

  localparam int BCW = gc_clog2(WIDTH);
  localparam int RW  = gc_clog2(RPT_LIMIT + 1);
  localparam int CW  = gc_clog2(DEPTH + 1);

  logic [WIDTH-2:0]  sr_q, sr_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [RW-1:0]     run_len_q, run_len_d;
  logic              last_bit_q, last_bit_d;
  logic              overflow_q, overflow_d;
  logic              stuck_q, stuck_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic [WIDTH-1:0]  word_c;
  logic              word_done;
  logic              stuck_set;
  logic              drop_evt;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_cnt;
  logic [WIDTH-1:0]  fifo_rdata;

  assign word_c    = {sr_q, bit_in_i};
  assign word_done = bit_en_i && (bit_cnt_q == BCW'(WIDTH - 1));
  assign fifo_pop  = !fifo_empty && word_if.word_ready;
  assign drop_evt  = word_done && fifo_full && !fifo_pop;

  gc_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (word_done),
    .wdata_i (word_c),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign word_if.word_out   = fifo_rdata;
  assign word_if.word_valid = !fifo_empty;

  always_comb begin
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    if (bit_en_i) begin
      sr_d      = word_c[WIDTH-2:0];
      bit_cnt_d = word_done ? '0 : bit_cnt_q + BCW'(1);
    end
  end

  // run_len==0 marks "no bit seen yet", so the first sample always starts a run.
  always_comb begin
    run_len_d  = run_len_q;
    last_bit_d = last_bit_q;
    if (bit_en_i) begin
      last_bit_d = bit_in_i;
      if ((run_len_q != '0) && (bit_in_i == last_bit_q)) begin
        run_len_d = (run_len_q == RW'(RPT_LIMIT)) ? run_len_q : run_len_q + RW'(1);
      end else begin
        run_len_d = RW'(1);
      end
    end
  end

  assign stuck_set = bit_en_i && (run_len_d == RW'(RPT_LIMIT));

  // A set event in the same cycle as clr wins, counting from zero.
  always_comb begin
    overflow_d = overflow_q;
    stuck_d    = stuck_q;
    drop_d     = drop_q;
    if (clr_i) begin
      overflow_d = 1'b0;
      stuck_d    = 1'b0;
      drop_d     = '0;
    end
    if (drop_evt) begin
      overflow_d = 1'b1;
      if (clr_i) begin
        drop_d = DROP_W'(1);
      end else begin
        drop_d = (&drop_q) ? drop_q : drop_q + DROP_W'(1);
      end
    end
    if (stuck_set) begin
      stuck_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      run_len_q  <= '0;
      last_bit_q <= 1'b0;
      overflow_q <= 1'b0;
      stuck_q    <= 1'b0;
      drop_q     <= '0;
    end else begin
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      run_len_q  <= run_len_d;
      last_bit_q <= last_bit_d;
      overflow_q <= overflow_d;
      stuck_q    <= stuck_d;
      drop_q     <= drop_d;
    end
  end

  assign overflow_o  = overflow_q;
  assign stuck_err_o = stuck_q;
  assign drop_cnt_o  = drop_q;

  a_full_matches_count : assert property (@(posedge clk_i) disable iff (!rst_ni)
    fifo_full == (fifo_cnt == CW'(DEPTH)));

endmodule

// File: tb/tb_gc_word_packer.sv
// Directed bench for gc_word_packer with hand-computed expected values.
module tb_gc_word_packer;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 4;
  localparam int RPT_LIMIT = 16;
  localparam int DROP_W    = 8;

  logic              clk;
  logic              rst_n;
  logic              bit_in;
  logic              bit_en;
  logic              clr;
  logic              overflow;
  logic              stuck_err;
  logic [DROP_W-1:0] drop_cnt;

  int checks;
  int errors;

  gc_word_packer_if #(.WIDTH(WIDTH)) wif ();

  gc_word_packer #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RPT_LIMIT (RPT_LIMIT),
    .DROP_W    (DROP_W)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bit_in_i    (bit_in),
    .bit_en_i    (bit_en),
    .clr_i       (clr),
    .word_if     (wif.master),
    .overflow_o  (overflow),
    .stuck_err_o (stuck_err),
    .drop_cnt_o  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bit_in = b;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  // Like send_word, but drives clr/word_ready specially on the final bit.
  task automatic send_word_last(input logic [7:0] w, input logic clr_l, input logic rdy_l);
    logic old_rdy;
    old_rdy = wif.word_ready;
    for (int i = 7; i >= 1; i--) send_bit(w[i]);
    clr = clr_l;
    wif.word_ready = rdy_l;
    send_bit(w[0]);
    clr = 1'b0;
    wif.word_ready = old_rdy;
  endtask

  task automatic expect_word(input string tag, input logic [7:0] w);
    check({tag, "_valid"}, 32'(wif.word_valid), 32'd1);
    check({tag, "_data"}, 32'(wif.word_out), 32'(w));
    tick();
  endtask

  initial begin
    logic [7:0] pat;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bit_in = 1'b0;
    bit_en = 1'b0;
    clr = 1'b0;
    wif.word_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(wif.word_valid), 32'd0);
    check("rst_word", 32'(wif.word_out), 32'h0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_stuck", 32'(stuck_err), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic packing: 1,0,1,1,0,0,1,0 -> B2 for one cycle
    wif.word_ready = 1'b1;
    pat = 8'hB2;
    for (int i = 7; i >= 1; i--) send_bit(pat[i]);
    check("basic_pre_valid", 32'(wif.word_valid), 32'd0);
    send_bit(pat[0]);
    check("basic_valid", 32'(wif.word_valid), 32'd1);
    check("basic_word", 32'(wif.word_out), 32'hB2);
    tick();
    check("basic_popped", 32'(wif.word_valid), 32'd0);

    // Enable gaps with inverted garbage on unsampled cycles
    for (int i = 7; i >= 0; i--) begin
      send_bit(pat[i]);
      if (i != 0) begin
        bit_in = ~pat[i];
        tick();
      end
    end
    check("gap_valid", 32'(wif.word_valid), 32'd1);
    check("gap_word", 32'(wif.word_out), 32'hB2);
    tick();
    check("gap_popped", 32'(wif.word_valid), 32'd0);

    // Overflow: fill, drop E5, drop F6 with clr (set wins), saturate drop_cnt
    wif.word_ready = 1'b0;
    send_word(8'hA1);
    send_word(8'hB2);
    send_word(8'hC3);
    send_word(8'hD4);
    check("full_head", 32'(wif.word_out), 32'hA1);
    check("full_no_ovf", 32'(overflow), 32'd0);
    send_word(8'hE5);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_drop1", 32'(drop_cnt), 32'd1);
    check("ovf_hold", 32'(wif.word_out), 32'hA1);
    send_word_last(8'hF6, 1'b1, 1'b0);
    check("ovf_clr_setwins_flag", 32'(overflow), 32'd1);
    check("ovf_clr_setwins_cnt", 32'(drop_cnt), 32'd1);
    for (int i = 0; i < 254; i++) send_word(8'h5A);
    check("drop_reach_max", 32'(drop_cnt), 32'd255);
    send_word(8'h5A);
    check("drop_saturate", 32'(drop_cnt), 32'd255);
    wif.word_ready = 1'b1;
    expect_word("drain0", 8'hA1);
    expect_word("drain1", 8'hB2);
    expect_word("drain2", 8'hC3);
    expect_word("drain3", 8'hD4);
    check("drain_empty", 32'(wif.word_valid), 32'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_overflow", 32'(overflow), 32'd0);
    check("clr_drop", 32'(drop_cnt), 32'd0);

    // Full with simultaneous pop: no drop, E5 delivered last
    wif.word_ready = 1'b0;
    send_word(8'hA1);
    send_word(8'hB2);
    send_word(8'hC3);
    send_word(8'hD4);
    send_word_last(8'hE5, 1'b0, 1'b1);
    check("fullpop_ovf", 32'(overflow), 32'd0);
    check("fullpop_drop", 32'(drop_cnt), 32'd0);
    wif.word_ready = 1'b1;
    expect_word("fp0", 8'hB2);
    expect_word("fp1", 8'hC3);
    expect_word("fp2", 8'hD4);
    expect_word("fp3", 8'hE5);
    check("fp_empty", 32'(wif.word_valid), 32'd0);

    // Stuck detection: run of 15 is fine, run of 16 trips
    send_bit(1'b0);
    for (int i = 0; i < 15; i++) send_bit(1'b1);
    check("stuck_15ones", 32'(stuck_err), 32'd0);
    send_bit(1'b0);
    check("stuck_break", 32'(stuck_err), 32'd0);
    for (int i = 0; i < 14; i++) send_bit(1'b0);
    check("stuck_15zeros", 32'(stuck_err), 32'd0);
    send_bit(1'b0);
    check("stuck_16zeros", 32'(stuck_err), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("stuck_clr", 32'(stuck_err), 32'd0);
    send_bit(1'b1);
    for (int i = 0; i < 14; i++) send_bit(1'b1);
    check("stuck_pre_clr_race", 32'(stuck_err), 32'd0);
    clr = 1'b1;
    send_bit(1'b1);
    clr = 1'b0;
    check("stuck_clr_race", 32'(stuck_err), 32'd1);

    // Reset mid-operation: 2 words buffered plus 5 partial bits
    wif.word_ready = 1'b0;
    send_word(8'h11);
    send_word(8'h22);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("midrst_pre_valid", 32'(wif.word_valid), 32'd1);
    rst_n = 1'b0;
    #2;
    check("midrst_async_valid", 32'(wif.word_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    check("midrst_word", 32'(wif.word_out), 32'h0);
    check("midrst_drop", 32'(drop_cnt), 32'd0);
    check("midrst_stuck", 32'(stuck_err), 32'd0);
    pat = 8'h3C;
    for (int i = 7; i >= 1; i--) send_bit(pat[i]);
    check("fresh_pre_valid", 32'(wif.word_valid), 32'd0);
    send_bit(pat[0]);
    check("fresh_valid", 32'(wif.word_valid), 32'd1);
    check("fresh_word", 32'(wif.word_out), 32'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gc_word_packer.md
Name: gc_word_packer

Overview:
Consumes the single-bit keystream of the Gollmann cascade generator and packs sampled bits into WIDTH-bit words. Completed words are buffered in a small FIFO and presented on a valid/ready interface to downstream consumers such as a bus register or DMA.
An online repetition-count health test flags a stuck keystream. Sticky overflow/stuck flags and a drop counter are exposed for software.

Parameters:
WIDTH, 8, bits per packed output word (>=2)
DEPTH, 4, FIFO depth in words (power of 2, >=2)
RPT_LIMIT, 16, consecutive identical sampled bits that raise stuck_err (>=2)
DROP_W, 8, width of the saturating drop counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
bit_in  in  1  keystream bit (cascade generator output)
bit_en  in  1  sample bit_in this cycle
clr  in  1  synchronous clear of overflow, stuck_err, drop_cnt
word_out  out  WIDTH  FIFO head word
word_valid  out  1  FIFO non-empty
word_ready  in  1  consumer accepts word_out
overflow  out  1  sticky: a completed word was dropped
stuck_err  out  1  sticky: repetition-count failure
drop_cnt  out  DROP_W  saturating count of dropped words

Behaviour:
- Reset (rst=0, async): shift reg, bit counter, FIFO pointers/count, run_len, last_bit, overflow, stuck_err and drop_cnt all clear to 0. Outputs: word_valid=0, word_out=0. Any partial word is discarded.
- Packing is MSB-first. On bit_en: sr <= {sr[WIDTH-2:0], bit_in} and bit_cnt increments.
- When bit_cnt==WIDTH-1 and bit_en, the word {sr[WIDTH-2:0], bit_in} is pushed to the FIFO the same edge and bit_cnt wraps to 0.
- Latency: word_valid rises the cycle after the edge that samples the last bit of a word (FIFO empty case).
- bit_en=0: no state change in the packer or health test. Gaps are allowed anywhere within a word.
- FIFO: word_out is the registered head. Pop occurs on word_valid && word_ready.
- Push when count<DEPTH: accepted.
- Push when count==DEPTH with a same-cycle pop: accepted; count stays DEPTH.
- Push when count==DEPTH without a pop: word dropped, overflow<=1, drop_cnt<=drop_cnt+1, saturating at all-ones. FIFO contents are unchanged.
- Pop when empty is impossible (valid=0). Pointers wrap modulo DEPTH.
- word_out must hold stable while word_valid=1 and word_ready=0.
- Health test, on bit_en:
  - If run_len!=0 and bit_in==last_bit: run_len<=min(run_len+1, RPT_LIMIT).
  - Otherwise: run_len<=1.
  - last_bit<=bit_in.
  - If the new run_len==RPT_LIMIT: stuck_err<=1.
  - run_len width is clog2(RPT_LIMIT+1).
- The health test does not block packing; words keep flowing while stuck_err=1.
- clr=1 clears overflow, stuck_err and drop_cnt next edge. If a set condition occurs in the same cycle as clr, set wins (drop_cnt becomes 1, not incremented from its old value). clr does not affect FIFO, packer or run_len.
- Reset mid-word or mid-transfer drops all buffered and partial data. A consumer must ignore word_out while word_valid=0.

Decomposition:
- Shared package gc_pkg: default WIDTH/DEPTH/RPT_LIMIT/DROP_W constants and a clog2 helper function.
- One sub-module, gc_sync_fifo: parameterised WIDTH×DEPTH synchronous FIFO with push/pop/full/empty/count and async active-low rst.
- Packing, drop accounting and the health test stay in gc_word_packer.

Test Plan:
- Basic packing: WIDTH=8, word_ready=1, bit_en=1, bits 1,0,1,1,0,0,1,0 -> word_out=8'hB2 with word_valid=1 for exactly one cycle, starting the cycle after the 8th bit.
- Enable gaps: same 8 bits with bit_en toggling 1,0,1,0… -> still 8'hB2. Unsampled bit_in values ignored; run_len unchanged across gaps.
- Overflow: DEPTH=4, word_ready=0, feed 5 words A1,B2,C3,D4,E5 -> after the 5th: overflow=1, drop_cnt=1. Draining yields A1,B2,C3,D4 in order, then word_valid=0.
- Full with simultaneous pop: FIFO full, word_ready=1 on the cycle the 5th word completes -> no drop, overflow stays 0, 5th word is delivered last.
- Stuck detection: RPT_LIMIT=16:
  - 15 ones then a 0 -> stuck_err=0.
  - Then 16 zeros -> stuck_err=1 after the 16th.
  - clr pulse -> stuck_err=0.
  - clr asserted in the same cycle as the 16th repeat -> stuck_err=1.
- Reset mid-operation: 5 of 8 bits fed and 2 words buffered, pulse rst=0 -> word_valid=0, drop_cnt=0. The next 8 sampled bits form a complete fresh word.
